ili9341_frame_sequencer: RTL and testbench

- Upstream feeder for the ILI9341 9-bit SPI master (word = {dc, byte}; dc=0 command, dc=1 data).
- Drives the panel hardware reset pin and issues a fixed init sequence with timed delays.
- Then loops forever: sets the full-screen window, sends RAMWR, and streams RGB565 pixels from a valid/ready source as two bytes each, high byte first.

---
 rtl/ili9341_pkg.sv | 61 ++++++
 rtl/ili9341_init_rom.sv | 28 ++
 rtl/ili9341_frame_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ili9341_frame_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ili9341_pkg.sv
// ili9341_pkg: shared definitions for the ILI9341 frame sequencer.
//   - panel command opcodes and fixed init data bytes
//   - DC bit encodings for the 9-bit SPI word {dc, byte}
//   - sequencer state enum, word-source enum
//   - init-table entry type {kind, value}
package ili9341_pkg;

   localparam logic [7:0] SWRESET      = 8'h01;
   localparam logic [7:0] SLPOUT       = 8'h11;
   localparam logic [7:0] COLMOD       = 8'h3A;
   localparam logic [7:0] MADCTL       = 8'h36;
   localparam logic [7:0] DISPON       = 8'h29;
   localparam logic [7:0] CASET        = 8'h2A;
   localparam logic [7:0] PASET        = 8'h2B;
   localparam logic [7:0] RAMWR        = 8'h2C;
   localparam logic [7:0] COLMOD_16BPP = 8'h55;
   localparam logic [7:0] MADCTL_VAL   = 8'h48;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   // Header is 11 words: CASET + 4 data, PASET + 4 data, RAMWR.
   localparam logic [3:0] HDR_LAST   = 4'd10;
   localparam int         INIT_IDX_W = 4;

   typedef enum logic [3:0] {
      ST_RST_LOW,
      ST_RST_WAIT,
      ST_INIT,
      ST_DELAY,
      ST_HEADER,
      ST_PIX_WAIT,
      ST_PIX_HI,
      ST_PIX_LO,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_t;

   // Which producer issued the word currently in flight; decides where
   // WAIT_DONE goes next.
   typedef enum logic [1:0] {
      SRC_INIT,
      SRC_HDR,
      SRC_PIX_HI,
      SRC_PIX_LO
   } src_t;

   typedef enum logic [1:0] {
      ENT_CMD,
      ENT_DATA,
      ENT_DELAY,
      ENT_END
   } kind_t;

   typedef struct packed {
      kind_t      kind;
      logic [7:0] value;
   } init_entry_t;

endpackage

// File: rtl/ili9341_init_rom.sv
// ili9341_init_rom: combinational init table, index -> entry.
// Ports:
//   idx    in   init table index
//   entry  out  {kind, value}; indices past the table return END
module ili9341_init_rom
   import ili9341_pkg::*;
(
   input  logic [INIT_IDX_W-1:0] idx,
   output init_entry_t           entry
);

   always_comb begin
      entry = '{kind: ENT_END, value: 8'h00};
      case (idx)
         4'd0:    entry = '{kind: ENT_CMD,   value: SWRESET};
         4'd1:    entry = '{kind: ENT_DELAY, value: 8'h00};
         4'd2:    entry = '{kind: ENT_CMD,   value: SLPOUT};
         4'd3:    entry = '{kind: ENT_DELAY, value: 8'h00};
         4'd4:    entry = '{kind: ENT_CMD,   value: COLMOD};
         4'd5:    entry = '{kind: ENT_DATA,  value: COLMOD_16BPP};
         4'd6:    entry = '{kind: ENT_CMD,   value: MADCTL};
         4'd7:    entry = '{kind: ENT_DATA,  value: MADCTL_VAL};
         4'd8:    entry = '{kind: ENT_CMD,   value: DISPON};
         default: entry = '{kind: ENT_END,   value: 8'h00};
      endcase
   end

endmodule

// File: rtl/ili9341_frame_sequencer.sv
// ili9341_frame_sequencer: feeds an ILI9341 9-bit SPI master.
// Pulses the panel reset, walks the init table (with timed delays), then
// loops forever: full-screen window, RAMWR, WIDTH*HEIGHT RGB565 pixels sent
// high byte first.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   lcd_rst_n    panel hardware reset (active low)
//   spi_idle     idle flag from the SPI master
//   spi_data     word to the master {dc, byte}; held between strobes
//   spi_valid    one-cycle load strobe, only issued while spi_idle=1
//   pix_data/pix_valid/pix_ready  pixel input stream
//   init_done    sticky once the init table has completed
//   frame_start  one-cycle pulse when the RAMWR word completes
//   dbg_state    current sequencer state
// Build option: define ILI_SEQ_TEST_PATTERN_EN to replace the pixel input
// with an internal 8-bar colour pattern (pix_ready then tied 0).
//
// Pixel handshake: a pixel transfers on a rising clk edge where pix_valid and
// pix_ready are both high; pix_ready is high only while waiting for a pixel,
// and the source must hold pix_data stable while pix_valid is high.
module ili9341_frame_sequencer
   import ili9341_pkg::*;
#(
   parameter int WIDTH              = 240,
   parameter int HEIGHT             = 320,
   parameter int RST_LOW_CYCLES     = 100000,
   parameter int RST_WAIT_CYCLES    = 1200000,
   parameter int SLPOUT_WAIT_CYCLES = 1200000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        lcd_rst_n,
   input  logic        spi_idle,
   output logic [8:0]  spi_data,
   output logic        spi_valid,
   input  logic [15:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        init_done,
   output logic        frame_start,
   output state_t      dbg_state
);

   localparam int MAX_A   = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
   localparam int MAX_DLY = (MAX_A > SLPOUT_WAIT_CYCLES) ? MAX_A : SLPOUT_WAIT_CYCLES;
   localparam int DLY_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
   localparam int NPIX    = WIDTH * HEIGHT;
   localparam int PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;

   localparam logic [DLY_W-1:0] RST_LOW_LAST  = DLY_W'(RST_LOW_CYCLES - 1);
   localparam logic [DLY_W-1:0] RST_WAIT_LAST = DLY_W'(RST_WAIT_CYCLES - 1);
   localparam logic [DLY_W-1:0] SLP_LAST      = DLY_W'(SLPOUT_WAIT_CYCLES - 1);
   localparam logic [PIX_W-1:0] PIX_LAST      = PIX_W'(NPIX - 1);
   localparam logic [15:0]      COL_END       = 16'(WIDTH - 1);
   localparam logic [15:0]      ROW_END       = 16'(HEIGHT - 1);

   state_t                state, state_d;
   src_t                  src, src_d;
   logic [DLY_W-1:0]      dly_cnt, dly_cnt_d;
   logic [INIT_IDX_W-1:0] init_idx, init_idx_d;
   logic [3:0]            hdr_idx, hdr_idx_d;
   logic [PIX_W-1:0]      pix_cnt, pix_cnt_d;
   logic [15:0]           pix, pix_d;
   logic [8:0]            word_d;
   logic                  init_done_d;
   init_entry_t           entry;
   logic [15:0]           next_pix;
   logic                  take_pix;

   ili9341_init_rom u_rom (
      .idx   (init_idx),
      .entry (entry)
   );

   function automatic logic [8:0] hdr_word(input logic [3:0] i);
      case (i)
         4'd0:    hdr_word = {DC_CMD,  CASET};
         4'd3:    hdr_word = {DC_DATA, COL_END[15:8]};
         4'd4:    hdr_word = {DC_DATA, COL_END[7:0]};
         4'd5:    hdr_word = {DC_CMD,  PASET};
         4'd8:    hdr_word = {DC_DATA, ROW_END[15:8]};
         4'd9:    hdr_word = {DC_DATA, ROW_END[7:0]};
         4'd10:   hdr_word = {DC_CMD,  RAMWR};
         default: hdr_word = {DC_DATA, 8'h00};   // start coordinates are 0
      endcase
   endfunction

`ifdef ILI_SEQ_TEST_PATTERN_EN
   localparam int BAR_W = (WIDTH >= 8) ? WIDTH / 8 : 1;
   localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [COL_W-1:0] col;
   logic [2:0]       bar;
   logic             col_step;

   // Column advances when a pixel's low byte completes.
   assign col_step = (state == ST_WAIT_DONE) && spi_idle && (src == SRC_PIX_LO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           col <= '0;
      else if (col_step) col <= (col == COL_W'(WIDTH - 1)) ? '0 : col + 1'b1;
   end

   always_comb begin
      int bar_i;
      bar_i = int'(col) / BAR_W;
      bar   = (bar_i > 7) ? 3'd7 : 3'(bar_i);
      case (bar)
         3'd0:    next_pix = 16'hFFFF;
         3'd1:    next_pix = 16'hFFE0;
         3'd2:    next_pix = 16'h07FF;
         3'd3:    next_pix = 16'h07E0;
         3'd4:    next_pix = 16'hF81F;
         3'd5:    next_pix = 16'hF800;
         3'd6:    next_pix = 16'h001F;
         default: next_pix = 16'h0000;
      endcase
   end

   assign take_pix  = 1'b1;
   assign pix_ready = 1'b0;
`else
   assign next_pix  = pix_data;
   assign take_pix  = pix_valid;
   assign pix_ready = (state == ST_PIX_WAIT);
`endif

   assign lcd_rst_n = (state != ST_RST_LOW);
   assign dbg_state = state;

   always_comb begin
      state_d     = state;
      src_d       = src;
      dly_cnt_d   = dly_cnt;
      init_idx_d  = init_idx;
      hdr_idx_d   = hdr_idx;
      pix_cnt_d   = pix_cnt;
      pix_d       = pix;
      word_d      = spi_data;
      init_done_d = init_done;
      spi_valid   = 1'b0;
      frame_start = 1'b0;
      case (state)
         ST_RST_LOW: begin
            if (dly_cnt == RST_LOW_LAST) begin
               dly_cnt_d = '0;
               state_d   = ST_RST_WAIT;
            end else dly_cnt_d = dly_cnt + 1'b1;
         end
         ST_RST_WAIT: begin
            if (dly_cnt == RST_WAIT_LAST) begin
               dly_cnt_d = '0;
               state_d   = ST_INIT;
            end else dly_cnt_d = dly_cnt + 1'b1;
         end
         ST_INIT: begin
            case (entry.kind)
               ENT_CMD, ENT_DATA: begin
                  if (spi_idle) begin
                     word_d  = {(entry.kind == ENT_DATA) ? DC_DATA : DC_CMD, entry.value};
                     src_d   = SRC_INIT;
                     state_d = ST_ISSUE;
                  end
               end
               ENT_DELAY: begin
                  dly_cnt_d  = '0;
                  init_idx_d = init_idx + 1'b1;
                  state_d    = ST_DELAY;
               end
               default: begin
                  init_done_d = 1'b1;
                  hdr_idx_d   = '0;
                  state_d     = ST_HEADER;
               end
            endcase
         end
         ST_DELAY: begin
            if (dly_cnt == SLP_LAST) begin
               dly_cnt_d = '0;
               state_d   = ST_INIT;
            end else dly_cnt_d = dly_cnt + 1'b1;
         end
         ST_HEADER: begin
            if (spi_idle) begin
               word_d  = hdr_word(hdr_idx);
               src_d   = SRC_HDR;
               state_d = ST_ISSUE;
            end
         end
         ST_PIX_WAIT: begin
            if (take_pix) begin
               pix_d   = next_pix;
               state_d = ST_PIX_HI;
            end
         end
         ST_PIX_HI: begin
            if (spi_idle) begin
               word_d  = {DC_DATA, pix[15:8]};
               src_d   = SRC_PIX_HI;
               state_d = ST_ISSUE;
            end
         end
         ST_PIX_LO: begin
            if (spi_idle) begin
               word_d  = {DC_DATA, pix[7:0]};
               src_d   = SRC_PIX_LO;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            spi_valid = 1'b1;
            state_d   = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!spi_idle) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (spi_idle) begin
               case (src)
                  SRC_INIT: begin
                     init_idx_d = init_idx + 1'b1;
                     state_d    = ST_INIT;
                  end
                  SRC_HDR: begin
                     if (hdr_idx == HDR_LAST) begin
                        frame_start = 1'b1;
                        hdr_idx_d   = '0;
                        state_d     = ST_PIX_WAIT;
                     end else begin
                        hdr_idx_d = hdr_idx + 1'b1;
                        state_d   = ST_HEADER;
                     end
                  end
                  SRC_PIX_HI: state_d = ST_PIX_LO;
                  default: begin
                     if (pix_cnt == PIX_LAST) begin
                        pix_cnt_d = '0;
                        state_d   = ST_HEADER;
                     end else begin
                        pix_cnt_d = pix_cnt + 1'b1;
                        state_d   = ST_PIX_WAIT;
                     end
                  end
               endcase
            end
         end
         default: state_d = ST_RST_LOW;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RST_LOW;
         src       <= SRC_INIT;
         dly_cnt   <= '0;
         init_idx  <= '0;
         hdr_idx   <= '0;
         pix_cnt   <= '0;
         pix       <= '0;
         spi_data  <= 9'h100;
         init_done <= 1'b0;
      end else begin
         state     <= state_d;
         src       <= src_d;
         dly_cnt   <= dly_cnt_d;
         init_idx  <= init_idx_d;
         hdr_idx   <= hdr_idx_d;
         pix_cnt   <= pix_cnt_d;
         pix       <= pix_d;
         spi_data  <= word_d;
         init_done <= init_done_d;
      end
   end

endmodule

// File: tb/tb_ili9341_frame_sequencer.sv
// tb_ili9341_frame_sequencer: directed bench for ili9341_frame_sequencer with
// a small SPI master model (idle drops after a strobe, busy 16 cycles).
// Expected words are queued as {init_done, spi_data}; a monitor compares each
// strobed word against the queue head.
module tb_ili9341_frame_sequencer;
   import ili9341_pkg::*;

   localparam int WIDTH    = 4;
   localparam int HEIGHT   = 2;
   localparam int RST_LOW  = 10;
   localparam int RST_WAIT = 20;
   localparam int SLP      = 5;

   localparam logic [8:0] INIT_W [7]  = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};
   localparam logic [8:0] HDR_W  [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103,
                                          9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
   localparam logic [15:0] PIX_V [8]  = '{16'hABCD, 16'h1234, 16'hFFFF, 16'h0000,
                                          16'h8001, 16'h7FFE, 16'h5A5A, 16'hC33C};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        lcd_rst_n, spi_idle, spi_valid, pix_ready, init_done, frame_start;
   logic        pix_valid;
   logic [8:0]  spi_data;
   logic [15:0] pix_data;
   state_t      dbg_state;

   ili9341_frame_sequencer #(
      .WIDTH              (WIDTH),
      .HEIGHT             (HEIGHT),
      .RST_LOW_CYCLES     (RST_LOW),
      .RST_WAIT_CYCLES    (RST_WAIT),
      .SLPOUT_WAIT_CYCLES (SLP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .lcd_rst_n   (lcd_rst_n),
      .spi_idle    (spi_idle),
      .spi_data    (spi_data),
      .spi_valid   (spi_valid),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .init_done   (init_done),
      .frame_start (frame_start),
      .dbg_state   (dbg_state)
   );

   // ---------------- SPI master model ----------------
   logic model_idle = 1'b1;
   int   busy_cnt   = 0;
   logic hold_busy  = 1'b0;
   assign spi_idle = model_idle & ~hold_busy;

   always @(posedge clk) begin
      if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) model_idle <= 1'b1;
      end else if (spi_valid && spi_idle) begin
         model_idle <= 1'b0;
         busy_cnt   <= 16;
      end
   end

   // ---------------- scoreboard ----------------
   logic [9:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_words  = 0;
   int cyc      = 0;
   int fs_cnt   = 0;
   int t_word[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_ge(input string name, input int act, input int min);
      n_checks++;
      if (act >= min) n_pass++;
      else $display("FAIL %s: got %0d expected at least %0d", name, act, min);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_lcd_rst_n"},   32'(lcd_rst_n),   32'd0);
      check({tag, "_spi_valid"},   32'(spi_valid),   32'd0);
      check({tag, "_spi_data"},    32'(spi_data),    32'h100);
      check({tag, "_pix_ready"},   32'(pix_ready),   32'd0);
      check({tag, "_init_done"},   32'(init_done),   32'd0);
      check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
   endtask

   // monitor: sampled on the falling edge, away from the active edge
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (frame_start) fs_cnt++;
         if (spi_valid) begin
            check("strobe_while_idle", 32'(spi_idle), 32'd1);
            n_words++;
            t_word.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_word", {22'd0, init_done, spi_data}, 32'hFFFFFFFF);
            end else begin
               e = exp_q.pop_front();
               check("word", {22'd0, init_done, spi_data}, {22'd0, e});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_init();
      for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, INIT_W[i]});
   endtask

   task automatic push_header();
      for (int i = 0; i < 11; i++) exp_q.push_back({1'b1, HDR_W[i]});
   endtask

   // called at a falling edge just after rst is released
   task automatic measure_rst_low(input string name);
      int n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (lcd_rst_n) break;
      end
      check(name, 32'(n), 32'(RST_LOW));
   endtask

   task automatic wait_pix_ready(input string name);
      int n = 0;
      while (!pix_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(pix_ready), 32'd1);
   endtask

   task automatic send_pixel(input logic [15:0] p);
      exp_q.push_back({1'b1, 1'b1, p[15:8]});
      exp_q.push_back({1'b1, 1'b1, p[7:0]});
      pix_data  = p;
      pix_valid = 1'b1;
      wait_pix_ready("pixel_accept");
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int base;
      int bad_valid;
      int bad_ready;
      pix_valid = 1'b0;
      pix_data  = 16'h0000;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // reset release, hardware reset pulse, first word latency
      push_init();
      rst = 1'b0;
      measure_rst_low("rst_low_cycles");
      n = 0;
      while (n_words == 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_ge("first_word_delay", n, RST_WAIT);

      // init sequence with delays
      n = 0;
      while (!init_done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("init_done_rise", 32'(init_done), 32'd1);
      check("init_word_count", 32'(n_words), 32'd7);
      if (t_word.size() >= 3) begin
         check_ge("gap_swreset_slpout", t_word[1] - t_word[0], 19 + SLP);
         check_ge("gap_slpout_colmod", t_word[2] - t_word[1], 19 + SLP);
      end else begin
         check("init_timestamps", 32'(t_word.size()), 32'd3);
      end

      // first frame header
      push_header();
      wait_pix_ready("frame1_pix_wait");
      check("frame_start_pulses", 32'(fs_cnt), 32'd1);
      check("header_drained", 32'(exp_q.size()), 32'd0);

      // two pixels, then a long stall with pix_valid low
      send_pixel(PIX_V[0]);
      send_pixel(PIX_V[1]);
      wait_pix_ready("stall_entry");
      bad_valid = 0;
      bad_ready = 0;
      repeat (50) begin
         @(negedge clk);
         if (spi_valid) bad_valid++;
         if (!pix_ready) bad_ready++;
      end
      check("stall_no_strobe", 32'(bad_valid), 32'd0);
      check("stall_ready_high", 32'(bad_ready), 32'd0);
      check("stall_words", 32'(n_words), 32'(7 + 11 + 4));

      // rest of the frame; next word after the last pixel is a new header
      for (int i = 2; i < 8; i++) send_pixel(PIX_V[i]);
      push_header();

      // reset during the second header word of frame 2
      n = 0;
      while (n_words < 7 + 11 + 16 + 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reached_frame2_word2", 32'(n_words), 32'(7 + 11 + 16 + 2));
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      base = n_words;
      repeat (2) @(negedge clk);

      // restart with the master reporting busy: no strobe may be issued
      hold_busy = 1'b1;
      rst       = 1'b0;
      measure_rst_low("restart_rst_low_cycles");
      repeat (RST_WAIT + 20) @(negedge clk);
      check("busy_hold_no_strobe", 32'(n_words), 32'(base));
      check("busy_hold_parked", 32'(dbg_state), 32'(ST_INIT));
      check("busy_hold_spi_data", 32'(spi_data), 32'h100);

      push_init();
      hold_busy = 1'b0;
      n = 0;
      while (!init_done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("restart_init_done", 32'(init_done), 32'd1);
      check("restart_word_count", 32'(n_words - base), 32'd7);
      check("restart_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
